shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter N, default 8, SHALL set the data width; it matches the width of the downstream shifter.
REQ-002 Parameter AW, default 3, SHALL set the width of the shift-amount field; amount ranges 0..2^AW-1.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL be the command request; it is sampled only while the block is idle.
REQ-006 op  input  3  SHALL be the operation select: 0 LSL, 1 LSR, 2 ROR, 3 ROL, 4 ASR, 5-7 invalid.
REQ-007 data_in  input  N  SHALL be the operand, captured on acceptance.
REQ-008 amount  input  AW  SHALL be the number of single-bit shift steps, captured on acceptance.
REQ-009 sh_q  input  N  SHALL be the registered output Q of the downstream shifter.
REQ-010 sh_d  output  N  SHALL drive the shifter's D input with the captured operand.
REQ-011 sh_mode  output  4  SHALL drive the shifter's mode input.
REQ-012 busy  output  1  SHALL be high whenever state != IDLE.
REQ-013 done  output  1  SHALL be a registered one-cycle completion pulse.
REQ-014 result  output  N  SHALL be a registered final value, held until the next done.
REQ-015 err  output  1  SHALL be registered; it is updated with each done and is high when the completed op was invalid.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE; sh_mode is a pure decode of state and op_reg.
REQ-017 sh_mode SHALL be 4'b0000 (shifter load) in IDLE, LOAD and DONE.
REQ-018 In SHIFT, sh_mode SHALL map op as LSL->0001, LSR->0010, ROR->0011, ROL->0100, ASR->0101.
REQ-019 In IDLE with start=1, the edge SHALL capture data_reg<=data_in, op_reg<=op and cnt<=amount, then go to LOAD; when start=0 the block stays in IDLE.
REQ-020 In LOAD, the edge SHALL cause the shifter to load data_reg; the next state is DONE if cnt==0 or op is invalid, else SHIFT.
REQ-021 In SHIFT, each edge SHALL perform one shifter step and decrement cnt; the edge where cnt==1 goes to DONE.
REQ-022 In DONE, the edge SHALL set result<=sh_q, done<=1, err<=(op_reg>4) and go to IDLE; at all other edges done<=0.
REQ-023 Latency SHALL be amount+2 cycles from the accept edge to the edge asserting done; for an invalid op it SHALL be 2 cycles.
REQ-024 An invalid op SHALL perform zero shift steps, so result equals the captured data_in.
REQ-025 start while busy=1 SHALL be ignored with no queuing; the current operation is unaffected.
REQ-026 The cycle in which done=1 is an IDLE cycle, so start in that cycle SHALL be accepted (back-to-back commands).
REQ-027 data_in, op and amount changing after acceptance SHALL have no effect on the running command.
REQ-028 sh_d SHALL equal data_reg at all times.

Reset
REQ-029 When rst_n=0, the block SHALL go asynchronously to IDLE with data_reg, cnt, op_reg, result=0, done=0, err=0 and busy=0, so sh_mode=0000 and sh_d=0.
REQ-030 Reset during LOAD, SHIFT or DONE SHALL abort the command with no done pulse; after release the block accepts a new start.

Verification
REQ-031 Assert rst_n=0 in the middle of SHIFT -> the outputs go immediately to busy=0, done=0, result=0, sh_mode=0000, with no done pulse after release.
REQ-032 LSL, data_in=8'b1001_0110, amount=3 -> result=8'b1011_0000, err=0, done exactly 5 cycles after the accept edge.
REQ-033 ASR, data_in=8'b1000_0100, amount=2 -> result=8'b1110_0001; ROL, data_in=8'b1000_0001, amount=7 -> result=8'b1100_0000.
REQ-034 LSR, data_in=8'hA5, amount=0 -> result=8'hA5 after 2 cycles, with no SHIFT cycle seen on sh_mode.
REQ-035 op=3'b110, data_in=8'h3C, amount=5 -> result=8'h3C, err=1, done after 2 cycles; the following valid op clears err.
REQ-036 start pulsed while busy -> ignored; start in the done cycle with ROR, 8'h01, amount 1 -> accepted, result=8'h80.

Source files
------------

// File: rtl/shift_sequencer.sv
// Sequences a registered single-step shifter: it captures a command, loads the
// operand into the shifter, steps it `amount` times and returns the final value.
module shift_sequencer #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [N-1:0]  data_in,
    input  logic [AW-1:0] amount,
    input  logic [N-1:0]  sh_q,
    output logic [N-1:0]  sh_d,
    output logic [3:0]    sh_mode,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ROR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;

    localparam logic [3:0] MODE_LOAD = 4'b0000;
    localparam logic [3:0] MODE_LSL  = 4'b0001;
    localparam logic [3:0] MODE_LSR  = 4'b0010;
    localparam logic [3:0] MODE_ROR  = 4'b0011;
    localparam logic [3:0] MODE_ROL  = 4'b0100;
    localparam logic [3:0] MODE_ASR  = 4'b0101;

    state_t        state;
    logic [N-1:0]  data_reg;
    logic [2:0]    op_reg;
    logic [AW-1:0] cnt;
    logic          op_invalid;

    assign op_invalid = (op_reg > OP_ASR);
    assign sh_d       = data_reg;
    assign busy       = (state != IDLE);

    // The shifter loads D in every state except SHIFT, so its Q always holds
    // the operand on the first SHIFT edge and the final value in DONE.
    always_comb begin
        sh_mode = MODE_LOAD;
        if (state == SHIFT) begin
            case (op_reg)
                OP_LSL:  sh_mode = MODE_LSL;
                OP_LSR:  sh_mode = MODE_LSR;
                OP_ROR:  sh_mode = MODE_ROR;
                OP_ROL:  sh_mode = MODE_ROL;
                OP_ASR:  sh_mode = MODE_ASR;
                default: sh_mode = MODE_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            op_reg   <= '0;
            cnt      <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_reg <= data_in;
                        op_reg   <= op;
                        cnt      <= amount;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Zero-step and invalid commands skip straight to completion.
                    if ((cnt == '0) || op_invalid) begin
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == AW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    result <= sh_q;
                    done   <= 1'b1;
                    err    <= op_invalid;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
